// File: rtl/seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// seq_pattern_detector
//
// Purpose:
//   Serial pattern checker that sits behind the three-input combinational
//   logic stage. It samples the upstream Y bit once per valid cycle, keeps a
//   PAT_LEN-deep shift history, and raises a registered single-cycle match
//   pulse when the newest PAT_LEN accepted bits equal PATTERN. A saturating
//   counter records the number of matches since reset or clear.
//
// Parameters:
//   PAT_LEN   pattern length in bits, legal range 2..16
//   PATTERN   target pattern; MSB is the oldest bit, LSB the newest bit
//   CNT_W     width of the match counter
//
// Ports:
//   clk_i        system clock, rising-edge active
//   reset_i      asynchronous active-high reset, clears all state at once
//   in_valid_i   in_bit_i is consumed this cycle
//   in_bit_i     serial data (Y of the upstream logic stage)
//   clear_i      synchronous clear of history, fill level and counter;
//                a bit presented in the same cycle is discarded
//   match_o      one-cycle registered match pulse
//   match_cnt_o  saturating match count since reset/clear
//   armed_o      high once PAT_LEN bits are held in the history
//
// Build option:
//   SEQ_DET_OVERLAP_EN  when defined, history and fill level are kept after a
//                       hit so a pattern suffix can start the next match.
//                       When undefined (default), a hit empties the history
//                       so the next match needs PAT_LEN fresh bits.
// -----------------------------------------------------------------------------
module seq_pattern_detector #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    input  logic             in_bit_i,
    input  logic             clear_i,
    output logic             match_o,
    output logic [CNT_W-1:0] match_cnt_o,
    output logic             armed_o
);

    // Fill level must be able to represent the value PAT_LEN itself.
    localparam int                 FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0]  FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    // Registered state
    logic [PAT_LEN-1:0] hist_q;
    logic [PAT_LEN-1:0] hist_d;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic               match_q;
    logic               match_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               armed_q;
    logic               armed_d;

    // Candidate values for an accepted bit
    logic [PAT_LEN-1:0] new_hist_s;
    logic [FILL_W-1:0]  new_fill_s;
    logic               hit_s;

    // Candidate history/fill level if the current bit were accepted.
    always_comb begin
        new_hist_s = {hist_q[PAT_LEN-2:0], in_bit_i};
        if (fill_q == FILL_FULL) begin
            new_fill_s = FILL_FULL;
        end else begin
            new_fill_s = fill_q + FILL_ONE;
        end
    end

    // Hit only when a bit is really accepted and the history is completely
    // filled with live bits: stale reset zeros must never complete a pattern
    // that begins with zeros. in_valid_i gates the term first so an unknown
    // in_bit_i on an idle cycle cannot reach the state.
    always_comb begin
        if (in_valid_i && !clear_i) begin
            hit_s = (new_fill_s == FILL_FULL) && (new_hist_s == PATTERN);
        end else begin
            hit_s = 1'b0;
        end
    end

    // Next-state selection: clear beats an accepted bit, idle cycles hold.
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        if (clear_i) begin
            hist_d  = '0;
            fill_d  = '0;
            match_d = 1'b0;
            cnt_d   = '0;
        end else if (in_valid_i) begin
            hist_d  = new_hist_s;
            fill_d  = new_fill_s;
            match_d = hit_s;
            if (hit_s && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
`ifdef SEQ_DET_OVERLAP_EN
            // Overlapping mode: keep history so a suffix can start a new match.
`else
            // Non-overlapping mode: a hit consumes the whole window.
            if (hit_s) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = new_hist_s;
                fill_d = new_fill_s;
            end
`endif
        end else begin
            hist_d  = hist_q;
            fill_d  = fill_q;
            match_d = 1'b0;
            cnt_d   = cnt_q;
        end
    end

    // armed mirrors the next fill level so it lines up with fill_q.
    always_comb begin
        if (fill_d == FILL_FULL) begin
            armed_d = 1'b1;
        end else begin
            armed_d = 1'b0;
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign match_o     = match_q;
    assign match_cnt_o = cnt_q;
    assign armed_o     = armed_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_detector
//
// Two detectors share one stimulus stream: one with the default pattern 1101
// and an 8-bit counter, one with pattern 0001 (leading zeros) and a 2-bit
// counter (saturation). A queue-based bit-history model produces the expected
// outputs per clock; a monitor pops and compares them after each edge.
// -----------------------------------------------------------------------------
module tb_seq_pattern_detector;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       clear;
    logic       match_a;
    logic [7:0] cnt_a;
    logic       armed_a;
    logic       match_b;
    logic [1:0] cnt_b;
    logic       armed_b;

    int checks = 0;
    int errors = 0;

    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .CNT_W(8)) dut_a (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_bit_i    (in_bit),
        .clear_i     (clear),
        .match_o     (match_a),
        .match_cnt_o (cnt_a),
        .armed_o     (armed_a)
    );

    seq_pattern_detector #(.PAT_LEN(4), .PATTERN(4'b0001), .CNT_W(2)) dut_b (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_bit_i    (in_bit),
        .clear_i     (clear),
        .match_o     (match_b),
        .match_cnt_o (cnt_b),
        .armed_o     (armed_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit hq [2][$];
    int mcnt [2];
    int pat_v [2];
    int cmax [2];
    int hits_b = 0;

    typedef struct {
        bit m0;
        int c0;
        bit a0;
        bit m1;
        int c1;
        bit a1;
    } exp_t;

    exp_t sb[$];

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            hq[k].delete();
            mcnt[k] = 0;
        end
    endfunction

    // One clock of the rules: remember the newest 4 accepted bits; a match is
    // those 4 bits (oldest first) reading as the pattern value.
    function automatic void model_step(int k, bit v, bit b, bit c,
                                       output bit m, output int cn, output bit ar);
        int val;
        m = 1'b0;
        if (c) begin
            hq[k].delete();
            mcnt[k] = 0;
        end else if (v) begin
            hq[k].push_back(b);
            if (hq[k].size() > 4) void'(hq[k].pop_front());
            if (hq[k].size() == 4) begin
                val = 0;
                foreach (hq[k][i]) val = val * 2 + int'(hq[k][i]);
                if (val == pat_v[k]) begin
                    m = 1'b1;
                    if (mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
`ifndef SEQ_DET_OVERLAP_EN
                    hq[k].delete();
`endif
                end
            end
        end
        cn = mcnt[k];
        ar = (hq[k].size() == 4);
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Apply one cycle of stimulus and record the expected post-edge outputs.
    task automatic drive(input bit v, input bit b, input bit c);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        clear    = c;
        model_step(0, v, b, c, e.m0, e.c0, e.a0);
        model_step(1, v, b, c, e.m1, e.c1, e.a1);
        sb.push_back(e);
    endtask

    task automatic send_bits(input int n, input logic [15:0] bits);
        logic [15:0] tmp;
        tmp = bits;
        for (int i = n - 1; i >= 0; i--) drive(1'b1, tmp[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    // Assert reset between edges and verify outputs drop before any clock.
    task automatic async_reset_check(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check({tag, "_match_a"}, int'(match_a), 0);
        check({tag, "_cnt_a"},   int'(cnt_a),   0);
        check({tag, "_armed_a"}, int'(armed_a), 0);
        check({tag, "_match_b"}, int'(match_b), 0);
        check({tag, "_cnt_b"},   int'(cnt_b),   0);
        check({tag, "_armed_b"}, int'(armed_b), 0);
        model_clear();
        in_valid = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compare every recorded expectation just after its clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("match_a", int'(match_a), int'(e.m0));
            check("cnt_a",   int'(cnt_a),   e.c0);
            check("armed_a", int'(armed_a), int'(e.a0));
            check("match_b", int'(match_b), int'(e.m1));
            check("cnt_b",   int'(cnt_b),   e.c1);
            check("armed_b", int'(armed_b), int'(e.a1));
            if (e.m1) hits_b++;
        end
    end

    initial begin
        int wait_cycles;
        pat_v[0] = 13;
        pat_v[1] = 1;
        cmax[0]  = 255;
        cmax[1]  = 3;
        model_clear();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        clear    = 1'b0;
        #12;
        check("reset_match_a", int'(match_a), 0);
        check("reset_cnt_a",   int'(cnt_a),   0);
        check("reset_armed_a", int'(armed_a), 0);
        check("reset_cnt_b",   int'(cnt_b),   0);
        @(negedge clk);
        reset = 1'b0;

        // Plan 1 and 2: single match, then overlapping continuation.
        send_bits(4, 16'b1101);
        idle(2);
        async_reset_check("rst1");
        send_bits(7, 16'b1101101);
        idle(2);
        // Plan 3: idle gaps inside the pattern.
        async_reset_check("rst2");
        send_bits(2, 16'b11);
        idle(3);
        send_bits(2, 16'b01);
        idle(2);
        // Plan 4: leading-zero pattern must not fire on stale zeros.
        async_reset_check("rst3");
        send_bits(1, 16'b1);
        idle(1);
        send_bits(4, 16'b0001);
        idle(1);
        // Plan 5: clear wins over the completing bit.
        send_bits(3, 16'b110);
        drive(1'b1, 1'b1, 1'b1);
        send_bits(4, 16'b1101);
        idle(1);
        // Plan 6: five matches on the 2-bit counter, then mid-stream reset.
        async_reset_check("rst4");
        hits_b = 0;
        for (int i = 0; i < 5; i++) send_bits(4, 16'b0001);
        send_bits(2, 16'b00);
        idle(2);
        check("sat_pulses_b", hits_b, 5);
        async_reset_check("rst5");

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 1000) == 999) begin
                async_reset_check("rst_rand");
            end else begin
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 63) == 0));
            end
        end
        idle(2);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #3;
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
